// File: rtl/tcdm_bank_tas_adapter.sv
// tcdm_bank_tas_adapter
// Per-bank stage between a TCDM interconnect memory-side port and one
// single-port SRAM macro. Forwards requests in the grant cycle, returns a
// response one cycle later and turns a read with add_i[TEST_SET_BIT] set into
// an atomic test-and-set: the old word is returned and the bank is written
// with all-ones in the very next cycle, during which no request is granted.
//
// Optional build macro: TCDM_BANK_RSP_REG_EN
//   defined   -> one extra register stage on r_data_o / r_valid_o / r_id_o
//                (response two cycles after grant, SRAM-side timing unchanged)
//   undefined -> response one cycle after grant
module tcdm_bank_tas_adapter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ADDR_MEM_WIDTH = 11,
  parameter int ID_WIDTH       = 20,
  parameter int TEST_SET_BIT   = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [ADDR_WIDTH-1:0]     add_i,
  input  logic                      wen_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [ID_WIDTH-1:0]       id_i,
  output logic [DATA_WIDTH-1:0]     r_data_o,
  output logic                      r_valid_o,
  output logic [ID_WIDTH-1:0]       r_id_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_MEM_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    TAS_WR = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_MEM_WIDTH-1:0] tas_idx_reg, tas_idx_next;
  logic                      rsp_valid_reg, rsp_valid_next;
  logic                      rsp_read_reg, rsp_read_next;
  logic [ID_WIDTH-1:0]       rsp_id_reg, rsp_id_next;

  logic [ADDR_MEM_WIDTH-1:0] req_idx;
  logic                      fire;
  logic                      rsp_valid_c;
  logic [DATA_WIDTH-1:0]     rsp_data_c;
  logic [ID_WIDTH-1:0]       rsp_id_c;

  // Only the word index reaches the SRAM; byte offset, the TAS flag and the
  // upper address bits are folded into a sink so they are visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{add_i[ADDR_WIDTH-1:ADDR_MEM_WIDTH+2], add_i[1:0]};
  assign req_idx          = add_i[ADDR_MEM_WIDTH+1:2];

  // Grant, SRAM drive and next state; everything is held at zero while rst_i
  // is high so a TAS write pending at reset is dropped.
  always_comb begin
    state_next   = state_reg;
    tas_idx_next = tas_idx_reg;
    gnt_o        = 1'b0;
    fire         = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    if (!rst_i) begin
      case (state_reg)
        IDLE: begin
          gnt_o       = 1'b1;
          fire        = req_i;
          mem_req_o   = req_i;
          mem_we_o    = ~wen_i;
          mem_addr_o  = req_idx;
          mem_wdata_o = data_i;
          mem_be_o    = be_i;
          if (req_i && wen_i && add_i[TEST_SET_BIT]) begin
            state_next   = TAS_WR;
            tas_idx_next = req_idx;
          end
        end
        TAS_WR: begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = tas_idx_reg;
          mem_wdata_o = {DATA_WIDTH{1'b1}};
          mem_be_o    = {BE_WIDTH{1'b1}};
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Remember what was granted so the response can be formed next cycle.
  always_comb begin
    rsp_valid_next = fire;
    rsp_read_next  = fire & wen_i;
    rsp_id_next    = fire ? id_i : rsp_id_reg;
  end

  // State and response-tracking registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      tas_idx_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_read_reg  <= 1'b0;
      rsp_id_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      tas_idx_reg   <= tas_idx_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_read_reg  <= rsp_read_next;
      rsp_id_reg    <= rsp_id_next;
    end
  end

  // Response is formed from the SRAM read port in the cycle after the grant;
  // writes answer with zero data and a reset cycle suppresses the response.
  always_comb begin
    rsp_valid_c = rsp_valid_reg & ~rst_i;
    rsp_data_c  = (rsp_valid_c && rsp_read_reg) ? mem_rdata_i : '0;
    rsp_id_c    = rst_i ? '0 : rsp_id_reg;
  end

`ifdef TCDM_BANK_RSP_REG_EN
  logic                  r_valid_reg;
  logic [DATA_WIDTH-1:0] r_data_reg;
  logic [ID_WIDTH-1:0]   r_id_reg;

  // Extra response pipeline stage for timing closure towards the interconnect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_reg <= 1'b0;
      r_data_reg  <= '0;
      r_id_reg    <= '0;
    end else begin
      r_valid_reg <= rsp_valid_c;
      r_data_reg  <= rsp_data_c;
      r_id_reg    <= rsp_id_c;
    end
  end

  assign r_valid_o = r_valid_reg;
  assign r_data_o  = r_data_reg;
  assign r_id_o    = r_id_reg;
`else
  assign r_valid_o = rsp_valid_c;
  assign r_data_o  = rsp_data_c;
  assign r_id_o    = rsp_id_c;
`endif

endmodule

// File: tb/tb_tcdm_bank_tas_adapter.sv
// Bench for tcdm_bank_tas_adapter: table of directed cycles, a reset-in-TAS
// sequence and randomized traffic, all checked against a memory-level model.
module tb_tcdm_bank_tas_adapter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int AMW = 11;
  localparam int IW  = 20;
  localparam int TSB = 20;
  localparam int BEW = DW / 8;
`ifdef TCDM_BANK_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_i, req_i, wen_i;
  logic [AW-1:0]  add_i;
  logic [DW-1:0]  data_i;
  logic [BEW-1:0] be_i;
  logic [IW-1:0]  id_i;
  logic           gnt_o, r_valid_o, mem_req_o, mem_we_o;
  logic [DW-1:0]  r_data_o, mem_wdata_o;
  logic [IW-1:0]  r_id_o;
  logic [AMW-1:0] mem_addr_o;
  logic [BEW-1:0] mem_be_o;
  logic [DW-1:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  tcdm_bank_tas_adapter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_MEM_WIDTH(AMW),
    .ID_WIDTH(IW), .TEST_SET_BIT(TSB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .wen_i(wen_i), .data_i(data_i), .be_i(be_i), .id_i(id_i),
    .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_id_o(r_id_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata)
  );

  // SRAM bank macro behaviour: byte-enabled write, registered read.
  logic [DW-1:0] sram [0:(1<<AMW)-1] = '{default: '0};
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BEW; b++)
          if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr_o];
      end
    end
  end

  // Reference model: expected memory contents, a pending-lock flag and the
  // queue of expected responses tagged with the cycle they must appear in.
  typedef struct {
    int            due;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } rsp_t;

  typedef struct {
    bit             rst;
    bit             req;
    bit             wen;
    logic [AW-1:0]  add;
    logic [DW-1:0]  data;
    logic [BEW-1:0] be;
    logic [IW-1:0]  id;
    bit             exp_gnt;
    bit             exp_mreq;
    bit             chk_rsp;
    logic [DW-1:0]  rsp;
  } vec_t;

  logic [DW-1:0] golden [0:(1<<AMW)-1];
  bit            tas_pend;
  int            tas_idx;
  rsp_t          q[$];
  int            cyc;
  int            checks;
  int            errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit req, input bit wen,
                              input logic [AW-1:0] add, input logic [DW-1:0] data,
                              input logic [BEW-1:0] be, input logic [IW-1:0] id,
                              input bit eg, input bit em, input bit cr,
                              input logic [DW-1:0] rsp);
    vec_t v;
    v.rst = rst; v.req = req; v.wen = wen; v.add = add; v.data = data;
    v.be = be; v.id = id; v.exp_gnt = eg; v.exp_mreq = em; v.chk_rsp = cr;
    v.rsp = rsp;
    return v;
  endfunction

  // One clock cycle: drive, sample at negedge, compare, advance the model.
  task automatic step(input vec_t t, input bit use_tab);
    bit            got_rsp;
    int            idx;
    logic [DW-1:0] d;
    rst_i = t.rst; req_i = t.req; wen_i = t.wen; add_i = t.add;
    data_i = t.data; be_i = t.be; id_i = t.id;
    @(negedge clk);
    if (t.rst)
      while (q.size() > 0 && q[$].due >= cyc + LAT - 1) void'(q.pop_back());
    got_rsp = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("r_valid", r_valid_o, 1);
      chk("r_id", r_id_o, q[0].id);
      chk("r_data", r_data_o, q[0].data);
      void'(q.pop_front());
      got_rsp = 1'b1;
    end else begin
      chk("r_valid_idle", r_valid_o, 0);
    end
    chk("gnt", gnt_o, !t.rst && !tas_pend);
    if (use_tab) begin
      chk("tab_gnt", gnt_o, t.exp_gnt);
      chk("tab_mem_req", mem_req_o, t.exp_mreq);
    end
    if (t.rst) begin
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_mem_be", mem_be_o, 0);
      if (!got_rsp && cyc > 0) begin
        chk("rst_r_data", r_data_o, 0);
        chk("rst_r_id", r_id_o, 0);
      end
      tas_pend = 1'b0;
    end else if (tas_pend) begin
      chk("tas_mem_req", mem_req_o, 1);
      chk("tas_mem_we", mem_we_o, 1);
      chk("tas_mem_addr", mem_addr_o, tas_idx);
      chk("tas_mem_wdata", mem_wdata_o, {DW{1'b1}});
      chk("tas_mem_be", mem_be_o, {BEW{1'b1}});
      golden[tas_idx] = {DW{1'b1}};
      tas_pend = 1'b0;
    end else begin
      chk("mem_req", mem_req_o, t.req);
      if (t.req) begin
        idx = int'(t.add[AMW+1:2]);
        chk("mem_we", mem_we_o, !t.wen);
        chk("mem_addr", mem_addr_o, idx);
        if (t.wen) begin
          d = golden[idx];
          if (t.add[TSB]) begin
            tas_pend = 1'b1;
            tas_idx  = idx;
          end
        end else begin
          chk("mem_wdata", mem_wdata_o, t.data);
          chk("mem_be", mem_be_o, t.be);
          for (int b = 0; b < BEW; b++)
            if (t.be[b]) golden[idx][b*8 +: 8] = t.data[b*8 +: 8];
          d = '0;
        end
        if (use_tab && t.chk_rsp) d = t.rsp;
        q.push_back('{cyc + LAT, t.id, d});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  vec_t tab[$];
  localparam logic [AW-1:0] TAS40 = 32'h0010_0040;
  localparam logic [DW-1:0] ONES  = 32'hFFFF_FFFF;

  initial begin
    vec_t r;
    logic [AW-1:0] a;
    checks = 0; errors = 0; cyc = 0; tas_pend = 1'b0; tas_idx = 0;
    for (int i = 0; i < (1 << AMW); i++) golden[i] = '0;
    rst_i = 1'b1; req_i = 1'b0; wen_i = 1'b1; add_i = '0;
    data_i = '0; be_i = '0; id_i = '0;

    //            rst req wen add           data          be    id  gnt mreq chk rsp
    tab.push_back(mk(1, 0, 1, 32'h0,        32'h0,        4'h0, 0,  0, 0, 0, 32'h0));
    tab.push_back(mk(1, 1, 1, 32'h40,       32'h0,        4'h0, 9,  0, 0, 0, 32'h0));
    tab.push_back(mk(0, 1, 0, 32'h40,       32'h1234_5678,4'hF, 3,  1, 1, 1, 32'h0));
    tab.push_back(mk(0, 1, 1, 32'h40,       32'h0,        4'h0, 4,  1, 1, 1, 32'h1234_5678));
    tab.push_back(mk(0, 1, 0, 32'h40,       32'h0,        4'hF, 5,  1, 1, 1, 32'h0));
    tab.push_back(mk(0, 1, 1, TAS40,        32'h0,        4'h0, 7,  1, 1, 1, 32'h0));
    tab.push_back(mk(0, 0, 1, 32'h0,        32'h0,        4'h0, 0,  0, 1, 0, 32'h0));
    tab.push_back(mk(0, 1, 1, 32'h40,       32'h0,        4'h0, 8,  1, 1, 1, ONES));
    tab.push_back(mk(0, 1, 1, TAS40,        32'h0,        4'h0, 9,  1, 1, 1, ONES));
    tab.push_back(mk(0, 1, 1, TAS40,        32'h0,        4'h0, 10, 0, 1, 0, 32'h0));
    tab.push_back(mk(0, 1, 1, TAS40,        32'h0,        4'h0, 10, 1, 1, 1, ONES));
    tab.push_back(mk(0, 1, 1, TAS40,        32'h0,        4'h0, 11, 0, 1, 0, 32'h0));
    tab.push_back(mk(0, 1, 1, TAS40,        32'h0,        4'h0, 11, 1, 1, 1, ONES));
    tab.push_back(mk(0, 0, 1, 32'h0,        32'h0,        4'h0, 0,  0, 1, 0, 32'h0));
    tab.push_back(mk(0, 1, 0, 32'h44,       32'hAABB_CCDD,4'h5, 20, 1, 1, 1, 32'h0));
    tab.push_back(mk(0, 1, 0, 32'h0010_0048,32'h55,       4'hF, 21, 1, 1, 1, 32'h0));
    tab.push_back(mk(0, 1, 1, 32'h40,       32'h0,        4'h0, 1,  1, 1, 1, ONES));
    tab.push_back(mk(0, 1, 1, 32'h44,       32'h0,        4'h0, 2,  1, 1, 1, 32'h00BB_00DD));
    tab.push_back(mk(0, 1, 1, 32'h48,       32'h0,        4'h0, 3,  1, 1, 1, 32'h55));
    tab.push_back(mk(0, 1, 1, 32'h4C,       32'h0,        4'h0, 4,  1, 1, 1, 32'h0));
    tab.push_back(mk(0, 0, 1, 32'h0,        32'h0,        4'h0, 0,  1, 0, 0, 32'h0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i], 1'b1);
      $display("vec %0d rst=%0b req=%0b wen=%0b add=%h id=%0d gnt=%0b mem_req=%0b",
               i, tab[i].rst, tab[i].req, tab[i].wen, tab[i].add, tab[i].id,
               gnt_o, mem_req_o);
    end

    // Reset lands on the TAS write cycle: the write is dropped, word unchanged.
    step(mk(0, 1, 1, 32'h0010_0044, 32'h0, 4'h0, 13, 1, 1, 0, 32'h0), 1'b1);
    step(mk(1, 0, 1, 32'h0,         32'h0, 4'h0, 0,  0, 0, 0, 32'h0), 1'b1);
    step(mk(0, 0, 1, 32'h0,         32'h0, 4'h0, 0,  1, 0, 0, 32'h0), 1'b1);
    step(mk(0, 1, 1, 32'h44,        32'h0, 4'h0, 14, 1, 1, 1, 32'h00BB_00DD), 1'b1);
    step(mk(0, 0, 1, 32'h0,         32'h0, 4'h0, 0,  1, 0, 0, 32'h0), 1'b1);
    step(mk(0, 0, 1, 32'h0,         32'h0, 4'h0, 0,  1, 0, 0, 32'h0), 1'b1);
    $display("reset-in-TAS sequence done at cycle %0d", cyc);

    // Randomized traffic on a handful of words to provoke TAS collisions.
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      a[AMW+1:2] = AMW'($urandom_range(0, 7));
      a[TSB] = ($urandom_range(0, 2) == 0);
      r = mk($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1, a, $urandom, BEW'($urandom),
             IW'($urandom), 0, 0, 0, 32'h0);
      step(r, 1'b0);
      if (r.req)
        $display("rnd %0d rst=%0b wen=%0b idx=%0d tas=%0b id=%h gnt=%0b",
                 i, r.rst, r.wen, r.add[AMW+1:2], r.add[TSB], r.id, gnt_o);
    end
    for (int i = 0; i < 4; i++)
      step(mk(0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 32'h0), 1'b0);
    chk("rsp_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
